// File: rtl/riscv_lsu_avalon_master.sv
// Purpose: adapts core load/store requests to a 32-bit word-addressed Avalon-MM RAM slave.
// Latency: store responds 2 cycles after accept; load responds 2+READ_LATENCY cycles after accept.
// Backpressure: req_ready is high only in IDLE/RESP; the response is a one-cycle pulse with no backpressure.
//
// Ports: clk/reset_n (synchronous, active-low); req_* request channel (valid/ready);
//        rsp_* completion pulse with load data and error flag; avm_* Avalon-MM master
//        (address, byteenable, chipselect, write, writedata out; readdata in).
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned / reserved-size
//        requests with rsp_err instead of silently aligning them.
module riscv_lsu_avalon_master #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Upper address bits beyond the RAM depth simply wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Incoming request decode: effective size/offset and rejection.
  logic [1:0]  in_size, in_off;
  logic        in_rej;
  logic [3:0]  in_be;
  logic [31:0] in_wdat;

  always_comb begin
    in_size = (req_size == 2'b11) ? SZ_W : req_size;
    in_off  = req_addr[1:0];
    in_rej  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    in_rej  = (req_size == 2'b11) ||
              ((req_size == SZ_H) && req_addr[0]) ||
              ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    // Misaligned accesses are silently aligned down to their natural boundary.
    if (in_size == SZ_H)      in_off[0] = 1'b0;
    else if (in_size == SZ_W) in_off    = 2'b00;
`endif
    case (in_size)
      SZ_B:    begin in_be = 4'b0001 << in_off;          in_wdat = {4{req_wdata[7:0]}};  end
      SZ_H:    begin in_be = 4'b0011 << {in_off[1], 1'b0}; in_wdat = {2{req_wdata[15:0]}}; end
      default: begin in_be = 4'b1111;                    in_wdat = req_wdata;            end
    endcase
  end

  // Load result: align the addressed lane to bit 0, then extend.
  logic [31:0] rd_shift, ld_data;

  always_comb begin
    rd_shift = avm_readdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    ld_data = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    ld_data = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  assign req_ready = (state_q == S_IDLE) || (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    off_d   = off_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_valid) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          size_d  = in_size;
          off_d   = in_off;
          // Avalon outputs are loaded here so they are registered during ISSUE.
          cs_d    = !in_rej;
          wr_d    = req_we && !in_rej;
          addr_d  = req_addr[ADDR_W+1:2];
          be_d    = in_be;
          wdat_d  = in_wdat;
          rdata_d = 32'd0;
          err_d   = in_rej;
          state_d = in_rej ? S_RESP : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = 2'(READ_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdat_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdat_q;

endmodule

// File: tb/tb_riscv_lsu_avalon_master.sv
// Purpose: self-checking bench for riscv_lsu_avalon_master (READ_LATENCY 1 and 3 instances).
// Latency: checks response cycle counts against the documented timing.
// Backpressure: drives one request at a time plus an overlapped request in the RESP cycle.
module tb_riscv_lsu_avalon_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, rst3_n;
  logic        req_valid, req_valid3;
  logic        req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready, rsp_valid, rsp_err, avm_cs, avm_wr;
  logic [31:0] rsp_rdata, avm_wdat, avm_rdat;
  logic [7:0]  avm_addr;
  logic [3:0]  avm_be;

  logic        req_ready3, rsp_valid3, rsp_err3, avm_cs3, avm_wr3;
  logic [31:0] rsp_rdata3, avm_wdat3, avm_rdat3;
  logic [7:0]  avm_addr3;
  logic [3:0]  avm_be3;

  riscv_lsu_avalon_master #(.ADDR_W(8), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_address(avm_addr), .avm_byteenable(avm_be), .avm_chipselect(avm_cs),
    .avm_write(avm_wr), .avm_writedata(avm_wdat), .avm_readdata(avm_rdat));

  riscv_lsu_avalon_master #(.ADDR_W(8), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .avm_address(avm_addr3), .avm_byteenable(avm_be3), .avm_chipselect(avm_cs3),
    .avm_write(avm_wr3), .avm_writedata(avm_wdat3), .avm_readdata(avm_rdat3));

  // RAM models: fixed read latency; non-read cycles return a poison pattern.
  logic [31:0] mem0 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 32'd0;
      mem0[4] <= 32'h8000_F0FF;
      mem0[1] <= 32'h1122_3344;
      pipe1   <= 32'd0;
    end else begin
      if (avm_cs && avm_wr)
        for (int b = 0; b < 4; b++)
          if (avm_be[b]) mem0[avm_addr][8*b +: 8] <= avm_wdat[8*b +: 8];
      pipe1 <= (avm_cs && !avm_wr) ? mem0[avm_addr] : 32'hDEAD_BEEF;
    end
  end
  assign avm_rdat = pipe1;

  always @(posedge clk) begin
    if (!rst3_n) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'd0;
      mem3[4] <= 32'h8000_F0FF;
    end else if (avm_cs3 && avm_wr3) begin
      for (int b = 0; b < 4; b++)
        if (avm_be3[b]) mem3[avm_addr3][8*b +: 8] <= avm_wdat3[8*b +: 8];
    end
    pipe3[0] <= (avm_cs3 && !avm_wr3) ? mem3[avm_addr3] : 32'hDEAD_BEEF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign avm_rdat3 = pipe3[2];

  int n_tests, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [7:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdat;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  // One complete transaction from IDLE; lat counts cycles after the accept edge.
  task automatic xact(input bit sel, input vec_t v, input string tag);
    int lat;
    @(posedge clk); #1;
    req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".ready"}, sel ? req_ready3 : req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid3 = 1'b0;
    @(negedge clk);
    chk({tag, ".cs"},   sel ? avm_cs3   : avm_cs,   1);
    chk({tag, ".wr"},   sel ? avm_wr3   : avm_wr,   {31'd0, v.we});
    chk({tag, ".addr"}, sel ? avm_addr3 : avm_addr, {24'd0, v.e_addr});
    chk({tag, ".be"},   sel ? avm_be3   : avm_be,   {28'd0, v.e_be});
    if (v.we) chk({tag, ".wdat"}, sel ? avm_wdat3 : avm_wdat, v.e_wdat);
    lat = 1;
    while (!(sel ? rsp_valid3 : rsp_valid) && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"},   lat, v.e_lat);
    chk({tag, ".rdata"}, sel ? rsp_rdata3 : rsp_rdata, v.e_rdata);
    chk({tag, ".err"},   sel ? rsp_err3 : rsp_err, 0);
  endtask

  localparam int NV = 13;
  vec_t vecs [NV];

  logic [5:0]  cs_pat, rv_pat;
  logic [31:0] b2b_rdata;
  bit          seen;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; rst3_n = 1'b0;
    req_valid = 1'b1; req_valid3 = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'd0;

    //            we    addr          sz     uns   wdata          eaddr  ebe      ewdat          erdata         lat
    vecs[0]  = '{1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'h0,         8'h04, 4'b1100, 32'h0,         32'hFFFF_8000, 3};
    vecs[1]  = '{1'b0, 32'h0000_0012, 2'b01, 1'b1, 32'h0,         8'h04, 4'b1100, 32'h0,         32'h0000_8000, 3};
    vecs[2]  = '{1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0,         8'h04, 4'b0001, 32'h0,         32'hFFFF_FFFF, 3};
    vecs[3]  = '{1'b0, 32'h0000_0011, 2'b00, 1'b1, 32'h0,         8'h04, 4'b0010, 32'h0,         32'h0000_00F0, 3};
    vecs[4]  = '{1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         8'h04, 4'b1111, 32'h0,         32'h8000_F0FF, 3};
    vecs[5]  = '{1'b1, 32'h0000_0013, 2'b00, 1'b0, 32'h1234_56A5, 8'h04, 4'b1000, 32'hA5A5_A5A5, 32'h0,         2};
    vecs[6]  = '{1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         8'h04, 4'b1111, 32'h0,         32'hA500_F0FF, 3};
    vecs[7]  = '{1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'hFFFF_BEEF, 8'h08, 4'b1100, 32'hBEEF_BEEF, 32'h0,         2};
    vecs[8]  = '{1'b0, 32'h0000_0022, 2'b01, 1'b0, 32'h0,         8'h08, 4'b1100, 32'h0,         32'hFFFF_BEEF, 3};
    vecs[9]  = '{1'b0, 32'h0000_0023, 2'b00, 1'b1, 32'h0,         8'h08, 4'b1000, 32'h0,         32'h0000_00BE, 3};
    vecs[10] = '{1'b1, 32'h0000_0404, 2'b10, 1'b0, 32'hCAFE_F00D, 8'h01, 4'b1111, 32'hCAFE_F00D, 32'h0,         2};
    vecs[11] = '{1'b0, 32'h0000_0004, 2'b10, 1'b0, 32'h0,         8'h01, 4'b1111, 32'h0,         32'hCAFE_F00D, 3};
    vecs[12] = '{1'b0, 32'h0000_0007, 2'b00, 1'b0, 32'h0,         8'h01, 4'b1000, 32'h0,         32'hFFFF_FFCA, 3};

    // Reset held 3 cycles with a pending request.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst.ready", req_ready, 1);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rsp_err", rsp_err, 0);
      chk("rst.rsp_rdata", rsp_rdata, 0);
      chk("rst.cs_wr", {avm_cs, avm_wr}, 0);
      chk("rst.addr_be", {avm_addr, avm_be}, 0);
      chk("rst.wdat", avm_wdat, 0);
    end
    reset_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rel.cs", avm_cs, 1);
    chk("rel.addr", avm_addr, 8'h04);
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
    chk("rel.lat", lat, 3);
    chk("rel.rdata", rsp_rdata, 32'h8000_F0FF);

    for (int i = 0; i < NV; i++) xact(1'b0, vecs[i], $sformatf("v%0d", i));

    // Back-to-back: store accepted in the RESP cycle of a load.
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    b2b_rdata = 32'd0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 2);
      if (c == 2) begin
        req_we = 1'b1; req_addr = 32'h30; req_size = 2'b10; req_wdata = 32'h1234_5678;
      end
      @(negedge clk);
      cs_pat[c] = avm_cs;
      rv_pat[c] = rsp_valid;
      if (c == 2) b2b_rdata = rsp_rdata;
    end
    chk("b2b.cs_pattern", {26'd0, cs_pat}, 32'b001001);
    chk("b2b.rsp_pattern", {26'd0, rv_pat}, 32'b010100);
    chk("b2b.load_rdata", b2b_rdata, 32'hA500_F0FF);
    xact(1'b0, '{1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 8'h0C, 4'b1111, 32'h0, 32'h1234_5678, 3}, "b2b.readback");

`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h6; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (avm_cs) seen = 1'b1;
      if (rsp_valid && lat == 0) begin
        lat = c;
        chk("mis.err", rsp_err, 1);
        chk("mis.rdata", rsp_rdata, 0);
      end
    end
    chk("mis.lat", lat, 1);
    chk("mis.no_cs", {31'd0, seen}, 0);
`else
    xact(1'b0, '{1'b0, 32'h6,  2'b10, 1'b0, 32'h0, 8'h01, 4'b1111, 32'h0, 32'hCAFE_F00D, 3}, "mis.word");
    xact(1'b0, '{1'b0, 32'h13, 2'b01, 1'b1, 32'h0, 8'h04, 4'b1100, 32'h0, 32'h0000_A500, 3}, "mis.half");
    xact(1'b0, '{1'b0, 32'h11, 2'b11, 1'b0, 32'h0, 8'h04, 4'b1111, 32'h0, 32'hA500_F0FF, 3}, "mis.size11");
`endif

    // READ_LATENCY=3: reset during WAIT discards the response.
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(negedge clk);
    chk("rl3.cs", avm_cs3, 1);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    @(negedge clk);
    seen = rsp_valid3;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    @(negedge clk);
    chk("rl3.ready_after_rst", req_ready3, 1);
    chk("rl3.cs_after_rst", avm_cs3, 0);
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid3) seen = 1'b1;
    end
    chk("rl3.no_rsp", {31'd0, seen}, 0);
    xact(1'b1, '{1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 8'h04, 4'b1100, 32'h0, 32'hFFFF_8000, 5}, "rl3.load");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
